// File: rtl/hi_sim_15693_rx.sv
// ISO 15693 tag-side receiver: pause detection with hysteresis and a glitch filter, SOF / 1-of-4 / EOF decode.
// Define HI_SIM_15693_FRAME_LEN_EN to build the saturating per-frame byte counter on frame_len.
module hi_sim_15693_rx #(
    parameter logic [7:0] PAUSE_LO  = 8'h10,
    parameter logic [7:0] PAUSE_HI  = 8'h40,
    parameter int         MIN_PAUSE = 48,
    parameter int         TOL       = 32
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic [7:0] adc_d,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_err,
    output logic       rx_busy,
    output logic       pause_det,
    output logic [7:0] frame_len
);
    localparam int               RUN_W       = $clog2(MIN_PAUSE + 2);
    localparam logic [RUN_W-1:0] RUN_CONFIRM = RUN_W'(MIN_PAUSE);
    localparam logic [RUN_W-1:0] RUN_SAT     = RUN_W'(MIN_PAUSE + 1);
    localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);
    localparam logic [9:0]       SOF_LATE    = 10'(640 + TOL);
    localparam logic [9:0]       T_LAST      = 10'd1023;

    typedef enum logic [1:0] {IDLE, SOF, DATA} state_t;

    logic [7:0]       adc_reg;
    logic             lvl;
    logic             lvl_reg;
    logic [RUN_W-1:0] run_reg;
    logic [RUN_W-1:0] run_next;
    logic [9:0]       edge_ts_reg;
    logic             confirm;
    logic             pause_det_reg;

    logic [9:0] t_reg, t_next;
    state_t     state_reg, state_next;
    logic       sof_ok_reg, sof_ok_next;
    logic       got_pause_reg, got_pause_next;
    logic [1:0] sym_cnt_reg, sym_cnt_next;
    logic [5:0] shift_reg, shift_next;
    logic [7:0] rx_byte_reg, rx_byte_next;
    logic       valid_reg, valid_next;
    logic       sof_reg, sof_next;
    logic       eof_reg, eof_next;
    logic       err_reg, err_next;

    logic [3:0] sym_hit;
    logic       sof_hit;
    logic       eof_hit;
    logic [1:0] sym_val;

    function automatic logic near(input logic [9:0] e, input int c);
        return (int'(e) >= c - TOL) && (int'(e) <= c + TOL);
    endfunction

    // Pause front end: input register, hysteresis level, run-length glitch filter.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            adc_reg       <= 8'hFF;  // reads as carrier so reset release is not a pause edge
            lvl_reg       <= 1'b0;
            run_reg       <= '0;
            edge_ts_reg   <= '0;
            pause_det_reg <= 1'b0;
        end else begin
            adc_reg <= adc_d;
            lvl_reg <= lvl;
            run_reg <= run_next;
            if (lvl && !lvl_reg)
                edge_ts_reg <= t_reg;
            if (confirm)
                pause_det_reg <= 1'b1;
            else if (!lvl)
                pause_det_reg <= 1'b0;
        end
    end

    always_comb begin
        lvl = lvl_reg;
        if (adc_reg <= PAUSE_LO)
            lvl = 1'b1;
        else if (adc_reg >= PAUSE_HI)
            lvl = 1'b0;
    end

    // Saturating one past the threshold makes each pause confirm exactly once.
    always_comb begin
        run_next = '0;
        if (lvl)
            run_next = (run_reg == RUN_SAT) ? RUN_SAT : run_reg + RUN_ONE;
    end

    assign confirm = (run_reg == RUN_CONFIRM);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sym
            assign sym_hit[gi] = near(edge_ts_reg, 128 + 256 * gi);
        end
    endgenerate

    assign sof_hit = near(edge_ts_reg, 640);
    assign eof_hit = near(edge_ts_reg, 256);

    always_comb begin
        sym_val = 2'd0;
        for (int i = 1; i < 4; i++)
            if (sym_hit[i])
                sym_val = 2'(i);
    end

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            t_reg         <= '0;
            state_reg     <= IDLE;
            sof_ok_reg    <= 1'b0;
            got_pause_reg <= 1'b0;
            sym_cnt_reg   <= '0;
            shift_reg     <= '0;
            rx_byte_reg   <= '0;
            valid_reg     <= 1'b0;
            sof_reg       <= 1'b0;
            eof_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            t_reg         <= t_next;
            state_reg     <= state_next;
            sof_ok_reg    <= sof_ok_next;
            got_pause_reg <= got_pause_next;
            sym_cnt_reg   <= sym_cnt_next;
            shift_reg     <= shift_next;
            rx_byte_reg   <= rx_byte_next;
            valid_reg     <= valid_next;
            sof_reg       <= sof_next;
            eof_reg       <= eof_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        t_next         = t_reg + 10'd1;
        sof_ok_next    = sof_ok_reg;
        got_pause_next = got_pause_reg;
        sym_cnt_next   = sym_cnt_reg;
        shift_next     = shift_reg;
        rx_byte_next   = rx_byte_reg;
        valid_next     = 1'b0;
        sof_next       = 1'b0;
        eof_next       = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (confirm) begin
                    // Re-base the timer so the pause edge sits at t = 0.
                    t_next      = t_reg - edge_ts_reg + 10'd1;
                    sof_ok_next = 1'b0;
                    state_next  = SOF;
                end
            end
            SOF: begin
                if (sof_ok_reg) begin
                    if (t_reg == T_LAST) begin
                        got_pause_next = 1'b0;
                        sym_cnt_next   = '0;
                        state_next     = DATA;
                    end
                end else if (confirm) begin
                    if (sof_hit) begin
                        sof_next    = 1'b1;
                        sof_ok_next = 1'b1;
                        shift_next  = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (t_reg > SOF_LATE && !lvl) begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                if (confirm) begin
                    if (got_pause_reg || !(|sym_hit || eof_hit)) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if (eof_hit) begin
                        eof_next   = 1'b1;
                        err_next   = (sym_cnt_reg != 2'd0);
                        state_next = IDLE;
                    end else begin
                        got_pause_next = 1'b1;
                        sym_cnt_next   = sym_cnt_reg + 2'd1;
                        shift_next     = {sym_val, shift_reg[5:2]};
                        if (sym_cnt_reg == 2'd3) begin
                            rx_byte_next = {sym_val, shift_reg};
                            valid_next   = 1'b1;
                        end
                    end
                end else if (t_reg == T_LAST) begin
                    if (!got_pause_reg) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                    got_pause_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef HI_SIM_15693_FRAME_LEN_EN
    logic [7:0] frame_len_reg, frame_len_next;

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst)
            frame_len_reg <= '0;
        else
            frame_len_reg <= frame_len_next;
    end

    always_comb begin
        frame_len_next = frame_len_reg;
        if (sof_next)
            frame_len_next = 8'd0;
        else if (valid_next && frame_len_reg != 8'hFF)
            frame_len_next = frame_len_reg + 8'd1;
    end

    assign frame_len = frame_len_reg;
`else
    assign frame_len = 8'd0;
`endif

    assign rx_byte   = rx_byte_reg;
    assign rx_valid  = valid_reg;
    assign rx_sof    = sof_reg;
    assign rx_eof    = eof_reg;
    assign rx_err    = err_reg;
    assign rx_busy   = (state_reg != IDLE);
    assign pause_det = pause_det_reg;

endmodule

// File: tb/tb_hi_sim_15693_rx.sv
// Scoreboard bench for hi_sim_15693_rx: frames are described as symbol lists, the expected strobes are
// derived from nominal pause offsets and pushed to a queue that a negedge monitor consumes.
module tb_hi_sim_15693_rx;
    localparam int         MIN_PAUSE = 48;
    localparam int         TOL       = 32;
    localparam logic [7:0] PAUSE_LO  = 8'h10;
    localparam logic [7:0] PAUSE_HI  = 8'h40;

    logic       ck_1356meg = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] adc_d = 8'hFF;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_sof, rx_eof, rx_err, rx_busy, pause_det;
    logic [7:0] frame_len;

    hi_sim_15693_rx #(
        .PAUSE_LO(PAUSE_LO), .PAUSE_HI(PAUSE_HI), .MIN_PAUSE(MIN_PAUSE), .TOL(TOL)
    ) dut (
        .ck_1356meg(ck_1356meg), .rst(rst), .adc_d(adc_d),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_err(rx_err), .rx_busy(rx_busy), .pause_det(pause_det), .frame_len(frame_len)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    int cyc = 0;
    always @(posedge ck_1356meg) cyc <= cyc + 1;

    typedef struct {
        int         when;
        bit         v, s, eo, er;
        logic [7:0] b;
        bit         busy;
        logic [7:0] fl;
    } ev_t;

    typedef struct {
        int start;
        int len;
    } pause_t;

    ev_t        exp_q[$];
    pause_t     pq[$];
    int         sym_q[$];
    logic [7:0] last_byte = 8'h00;
    int         flen = 0;

    int   checks = 0;
    int   errors = 0;
    int   probe_seq = 0;
    int   probe_done = 0;
    int   probe_kind = 0;
    ev_t  mon_e;

    // Monitor: every strobe cycle consumes one expected event; probes check idle/reset state.
    always @(negedge ck_1356meg) begin
        if (rx_valid || rx_sof || rx_eof || rx_err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected at cyc=%0d v/s/eo/er=%0b%0b%0b%0b byte=%02h, required none",
                         cyc, rx_valid, rx_sof, rx_eof, rx_err, rx_byte);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.when || rx_valid != mon_e.v || rx_sof != mon_e.s ||
                    rx_eof != mon_e.eo || rx_err != mon_e.er || rx_byte != mon_e.b ||
                    rx_busy != mon_e.busy || frame_len != mon_e.fl) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d v/s/eo/er=%0b%0b%0b%0b byte=%02h busy=%0b len=%0d, required cyc=%0d v/s/eo/er=%0b%0b%0b%0b byte=%02h busy=%0b len=%0d",
                             cyc, rx_valid, rx_sof, rx_eof, rx_err, rx_byte, rx_busy, frame_len,
                             mon_e.when, mon_e.v, mon_e.s, mon_e.eo, mon_e.er, mon_e.b, mon_e.busy, mon_e.fl);
                end else begin
                    $display("cyc=%0d event v/s/eo/er=%0b%0b%0b%0b byte=%02h len=%0d ok",
                             cyc, rx_valid, rx_sof, rx_eof, rx_err, rx_byte, frame_len);
                end
            end
        end
        if (probe_seq != probe_done) begin
            probe_done = probe_seq;
            checks++;
            if (probe_kind == 0) begin
                if (rx_busy || exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL idle: busy=%0b pending=%0d, required busy=0 pending=0",
                             rx_busy, exp_q.size());
                end else begin
                    $display("cyc=%0d idle ok", cyc);
                end
                exp_q.delete();
            end else begin
                if ({rx_byte, rx_valid, rx_sof, rx_eof, rx_err, rx_busy, pause_det, frame_len} != 22'd0) begin
                    errors++;
                    $display("FAIL reset: byte=%02h v/s/eo/er=%0b%0b%0b%0b busy=%0b pdet=%0b len=%0d, required all 0",
                             rx_byte, rx_valid, rx_sof, rx_eof, rx_err, rx_busy, pause_det, frame_len);
                end else begin
                    $display("cyc=%0d reset state ok", cyc);
                end
            end
        end
    end

    task automatic probe(input int kind);
        probe_kind = kind;
        probe_seq++;
        @(negedge ck_1356meg);
        #1;
    endtask

    function automatic int jit();
        return int'($urandom_range(0, 2 * TOL)) - TOL;
    endfunction

    function automatic bit in_pause(input int p);
        foreach (pq[i])
            if (p >= pq[i].start && p < pq[i].start + pq[i].len)
                return 1'b1;
        return 1'b0;
    endfunction

    // Band values only after a segment's first sample, so they exercise the hysteresis hold.
    function automatic logic [7:0] sample(input bit low, input bit first);
        if (!first && $urandom_range(0, 5) == 0)
            return 8'($urandom_range(int'(PAUSE_LO) + 1, int'(PAUSE_HI) - 1));
        if (low)
            return 8'($urandom_range(0, int'(PAUSE_LO)));
        return 8'($urandom_range(int'(PAUSE_HI), 255));
    endfunction

    task automatic drive_to(input int endp);
        bit low;
        bit prev_low = 1'b0;
        while (cyc < endp) begin
            @(posedge ck_1356meg);
            #1;
            low = in_pause(cyc + 1);
            adc_d = sample(low, low != prev_low);
            prev_low = low;
        end
    endtask

    task automatic expect_ev(input int when, input bit v, input bit s, input bit eo, input bit er,
                             input int cut);
        ev_t ev;
        if (when >= cut)
            return;
        ev.when = when;
        ev.v    = v;
        ev.s    = s;
        ev.eo   = eo;
        ev.er   = er;
        ev.b    = last_byte;
        ev.busy = !(eo || er);
`ifdef HI_SIM_15693_FRAME_LEN_EN
        ev.fl   = 8'(flen);
`else
        ev.fl   = 8'd0;
`endif
        exp_q.push_back(ev);
    endtask

    // fault: 0 none, 1 bad offset at symbol m, 2 missing pause in window m,
    //        3 second pause in window m, 4 SOF pause outside its window.
    task automatic run_frame(input int fault, input int m, input bit pre_glitch,
                             input int rst_at, input int bad_d);
        int e0, ws, edge_p, off, endp, acc, n, cut, d, len;
        bit done;
        n    = sym_q.size();
        done = 1'b0;
        acc  = 0;
        endp = 0;
        pq.delete();
        e0  = cyc + 300;
        cut = (rst_at >= 0) ? e0 + 1024 * (rst_at + 1) + 10 : 32'h7fffffff;
        if (pre_glitch)
            pq.push_back('{e0 - 150, 20});
        pq.push_back('{e0, int'($urandom_range(48, 120))});
        if (fault == 4) begin
            edge_p = e0 + 640 + TOL + int'($urandom_range(5, 200));
            pq.push_back('{edge_p, 60});
            endp = edge_p + 800;
            done = 1'b1;
        end else begin
            edge_p = e0 + 640 + jit();
            pq.push_back('{edge_p, int'($urandom_range(48, 100))});
            flen = 0;
            expect_ev(edge_p + MIN_PAUSE + 1, 0, 1, 0, 0, cut);
        end
        for (int k = 0; k < n && !done; k++) begin
            ws = e0 + 1024 * (k + 1);
            if ($urandom_range(0, 2) == 0)
                pq.push_back('{ws + 30, 20});
            if (fault == 2 && k == m) begin
                expect_ev(ws + 1024, 0, 0, 0, 1, cut);
                endp = ws + 1100;
                done = 1'b1;
            end else if (fault == 1 && k == m) begin
                d = (bad_d != 0) ? bad_d : TOL + int'($urandom_range(3, 40));
                if (bad_d == 0 && $urandom_range(0, 1) == 1)
                    d = -d;
                edge_p = ws + 128 + 256 * sym_q[k] + d;
                pq.push_back('{edge_p, 60});
                expect_ev(edge_p + MIN_PAUSE + 1, 0, 0, 0, 1, cut);
                endp = edge_p + 200;
                done = 1'b1;
            end else begin
                off    = 128 + 256 * sym_q[k];
                edge_p = ws + off + jit();
                len    = (fault == 3 && k == m) ? 60 : int'($urandom_range(48, 120));
                pq.push_back('{edge_p, len});
                acc += sym_q[k] << (2 * (k % 4));
                if (k % 4 == 3) begin
                    last_byte = 8'(acc);
                    if (flen < 255)
                        flen++;
                    acc = 0;
                    expect_ev(edge_p + MIN_PAUSE + 1, 1, 0, 0, 0, cut);
                end
                if (fault == 3 && k == m) begin
                    pq.push_back('{edge_p + 90, 50});
                    expect_ev(edge_p + 90 + MIN_PAUSE + 1, 0, 0, 0, 1, cut);
                    endp = edge_p + 300;
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            edge_p = e0 + 1024 * (n + 1) + 256 + jit();
            pq.push_back('{edge_p, int'($urandom_range(48, 120))});
            expect_ev(edge_p + MIN_PAUSE + 1, 0, 0, 1, (n % 4) != 0, cut);
            endp = edge_p + 200;
        end
        if (rst_at >= 0) begin
            drive_to(cut);
            rst = 1'b1;
            last_byte = 8'h00;
            flen = 0;
            probe(1);
            @(posedge ck_1356meg);
            #1;
            rst = 1'b0;
            pq.delete();
        end else begin
            drive_to(endp);
        end
        probe(0);
    endtask

    initial begin
        int n, f, m;
        rst = 1'b1;
        repeat (3) @(posedge ck_1356meg);
        #1;
        probe(1);
        rst = 1'b0;

        sym_q = '{1, 0, 2, 3};
        run_frame(0, 0, 1'b0, -1, 0);
        sym_q = '{3, 3};
        run_frame(0, 0, 1'b0, -1, 0);
        sym_q = '{2};
        run_frame(0, 0, 1'b1, -1, 0);
        sym_q = '{0, 1};
        run_frame(1, 0, 1'b0, -1, 50);
        sym_q = '{2, 1};
        run_frame(2, 1, 1'b0, -1, 0);
        sym_q = '{1, 2, 3, 0};
        run_frame(0, 0, 1'b0, 2, 0);
        sym_q = '{0, 0, 0, 0};
        run_frame(0, 0, 1'b0, -1, 0);
        sym_q = '{3, 2};
        run_frame(3, 1, 1'b0, -1, 0);
        sym_q = '{1};
        run_frame(4, 0, 1'b0, -1, 0);

        for (int r = 0; r < 5; r++) begin
            n = int'($urandom_range(0, 5));
            sym_q.delete();
            for (int k = 0; k < n; k++)
                sym_q.push_back(int'($urandom_range(0, 3)));
            f = (n == 0) ? 4 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 4));
            m = (n == 0) ? 0 : int'($urandom_range(0, n - 1));
            run_frame(f, m, $urandom_range(0, 1) == 1, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
